// File: rtl/inst_queue_pkg.sv
// Shared types and helpers for the 2-wide fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 8;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [XLEN-1:0] inst;
    } iq_entry_t;

    // Sequential PC of the younger instruction in a fetch pair (wraps mod 2^PCW).
    function automatic logic [PCW-1:0] pc_plus4(input logic [PCW-1:0] pc);
        return pc + PCW'(4);
    endfunction

endpackage

// File: rtl/inst_queue.sv
// 2-wide instruction queue: accepts up to two fetched instructions per cycle,
// presents the two oldest to decode and retires up to two per cycle.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid1,
    input  logic                     in_valid2,
    input  logic [PCW-1:0]           in_pc,
    input  logic [XLEN-1:0]          in_inst1,
    input  logic [XLEN-1:0]          in_inst2,
    output logic                     in_ready,
    output logic                     out_valid1,
    output logic                     out_valid2,
    output logic [XLEN-1:0]          out_inst1,
    output logic [PCW-1:0]           out_pc1,
    output logic [XLEN-1:0]          out_inst2,
    output logic [PCW-1:0]           out_pc2,
    input  logic [1:0]               deq_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    iq_entry_t        mem [DEPTH];
    logic [PTRW-1:0]  head;
    logic [PTRW-1:0]  tail;
    logic [CNTW-1:0]  count;
    logic [1:0]       enq;
    logic [1:0]       deq_req;
    logic [1:0]       deq;
    iq_entry_t        entry0;
    iq_entry_t        entry1;

    // Two free slots are required so a full pair can always be accepted.
    assign in_ready = (CNTW'(DEPTH) - count) >= CNTW'(2);

    // Enqueue/dequeue amounts; dequeue is clipped to two and to what is held.
    always_comb begin
        enq     = 2'd0;
        deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        deq     = deq_req;
        if (in_valid1 && in_ready) begin
            enq = in_valid2 ? 2'd2 : 2'd1;
        end
        if (count < CNTW'(deq_req)) begin
            deq = count[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTRW'(deq);
            tail  <= tail + PTRW'(enq);
            count <= count + CNTW'(enq) - CNTW'(deq);
        end
    end

    // Storage is never cleared; only pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (enq != 2'd0) begin
            mem[tail] <= '{pc: in_pc, inst: in_inst1};
        end
        if (enq == 2'd2) begin
            mem[tail + PTRW'(1)] <= '{pc: pc_plus4(in_pc), inst: in_inst2};
        end
    end

    assign entry0     = mem[head];
    assign entry1     = mem[head + PTRW'(1)];
    assign out_valid1 = count >= CNTW'(1);
    assign out_valid2 = count >= CNTW'(2);
    assign out_inst1  = out_valid1 ? entry0.inst : '0;
    assign out_pc1    = out_valid1 ? entry0.pc   : '0;
    assign out_inst2  = out_valid2 ? entry1.inst : '0;
    assign out_pc2    = out_valid2 ? entry1.pc   : '0;
    assign occupancy  = count;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid1, in_valid2;
    logic [7:0]  in_pc;
    logic [31:0] in_inst1, in_inst2;
    logic        in_ready, out_valid1, out_valid2;
    logic [31:0] out_inst1, out_inst2;
    logic [7:0]  out_pc1, out_pc2;
    logic [1:0]  deq_cnt;
    logic [3:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] mq[$];   // {pc, inst}, oldest first

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid1(in_valid1), .in_valid2(in_valid2), .in_pc(in_pc),
        .in_inst1(in_inst1), .in_inst2(in_inst2), .in_ready(in_ready),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_inst1(out_inst1), .out_pc1(out_pc1),
        .out_inst2(out_inst2), .out_pc2(out_pc2),
        .deq_cnt(deq_cnt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one clock edge, from the current inputs.
    task automatic model_step();
        int  n, d;
        bit  rdy;
        logic [7:0] p2;
        if (reset || flush) begin
            mq.delete();
        end else begin
            n   = mq.size();
            rdy = (DEPTH - n) >= 2;
            d   = (deq_cnt > 2) ? 2 : int'(deq_cnt);
            if (d > n) d = n;
            repeat (d) void'(mq.pop_front());
            if (in_valid1 && rdy) begin
                mq.push_back({in_pc, in_inst1});
                if (in_valid2) begin
                    p2 = in_pc + 8'd4;
                    mq.push_back({p2, in_inst2});
                end
            end
        end
    endtask

    function automatic logic [86:0] model_vec();
        logic [39:0] e0, e1;
        int n;
        n  = mq.size();
        e0 = '0;
        e1 = '0;
        if (n >= 1) e0 = mq[0];
        if (n >= 2) e1 = mq[1];
        return {(DEPTH - n) >= 2, n >= 1, n >= 2, e0[31:0], e0[39:32],
                e1[31:0], e1[39:32], 4'(n)};
    endfunction

    function automatic logic [86:0] dut_vec();
        return {in_ready, out_valid1, out_valid2, out_inst1, out_pc1,
                out_inst2, out_pc2, occupancy};
    endfunction

    task automatic drive(input bit v1, input bit v2, input logic [7:0] pc,
                         input logic [1:0] dq, input bit fl, input bit rs);
        in_valid1 = v1;
        in_valid2 = v2;
        in_pc     = pc;
        in_inst1  = $urandom;
        in_inst2  = $urandom;
        deq_cnt   = dq;
        flush     = fl;
        reset     = rs;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 8'h00, 2'd0, 0, 1);
        tick();
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_cmp++;
        if ({out_valid1, out_valid2} !== 2'b00) begin
            n_err++; $display("FAIL reset_valid got=%b%b exp=00", out_valid1, out_valid2);
        end
        n_cmp++;
        if (occupancy !== 4'd0) begin
            n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy);
        end
        n_cmp++;
        if ({out_inst1, out_pc1, out_inst2, out_pc2} !== 80'd0) begin
            n_err++; $display("FAIL reset_data got=%h exp=0", {out_inst1, out_pc1, out_inst2, out_pc2});
        end
    endtask

    task automatic test_pair();
        drive(1, 1, 8'h10, 2'd0, 0, 0);
        in_inst1 = 32'hAAAA0001;
        in_inst2 = 32'hAAAA0002;
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if ({out_pc1, out_inst1} !== {8'h10, 32'hAAAA0001}) begin
            n_err++; $display("FAIL pair_head got=%h/%h exp=10/AAAA0001", out_pc1, out_inst1);
        end
        n_cmp++;
        if ({out_pc2, out_inst2} !== {8'h14, 32'hAAAA0002}) begin
            n_err++; $display("FAIL pair_second got=%h/%h exp=14/AAAA0002", out_pc2, out_inst2);
        end
        n_cmp++;
        if (occupancy !== 4'd2) begin
            n_err++; $display("FAIL pair_occ got=%0d exp=2", occupancy);
        end
    endtask

    task automatic test_fill();
        drive(0, 0, 8'h00, 2'd0, 1, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 8'(8'h20 + 8 * k), 2'd0, 0, 0);
            tick();
        end
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if ({occupancy, in_ready} !== {4'd8, 1'b0}) begin
            n_err++; $display("FAIL fill_full got=%0d/%b exp=8/0", occupancy, in_ready);
        end
        drive(1, 1, 8'h90, 2'd0, 0, 0);
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if (occupancy !== 4'd8) begin
            n_err++; $display("FAIL fill_drop got=%0d exp=8", occupancy);
        end
        drive(0, 0, 8'h00, 2'd1, 0, 0);
        tick();
        n_cmp++;
        if ({occupancy, in_ready} !== {4'd7, 1'b0}) begin
            n_err++; $display("FAIL fill_minus1 got=%0d/%b exp=7/0", occupancy, in_ready);
        end
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if ({occupancy, in_ready, out_pc1} !== {4'd6, 1'b1, 8'h28}) begin
            n_err++; $display("FAIL fill_minus2 got=%0d/%b/%h exp=6/1/28", occupancy, in_ready, out_pc1);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL fill_model got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc;
        drive(0, 0, 8'h00, 2'd0, 1, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 8'(8'hF8 + 8 * i), 2'd2, 0, 0);
            if (i > 0) begin
                exp_pc = 8'(8'hF8 + 8 * (i - 1));
                n_cmp++;
                if ({occupancy, out_pc1, out_pc2} !== {4'd2, exp_pc, 8'(exp_pc + 8'd4)}) begin
                    n_err++; $display("FAIL wrap_%0d got=%0d/%h/%h exp=2/%h/%h", i, occupancy,
                                      out_pc1, out_pc2, exp_pc, 8'(exp_pc + 8'd4));
                end
                n_cmp++;
                if (dut_vec() !== model_vec()) begin
                    n_err++; $display("FAIL wrap_model_%0d got=%h exp=%h", i, dut_vec(), model_vec());
                end
            end
            tick();
        end
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if ({occupancy, out_pc1} !== {4'd2, 8'h40}) begin
            n_err++; $display("FAIL wrap_end got=%0d/%h exp=2/40", occupancy, out_pc1);
        end
    endtask

    task automatic test_over_deq();
        drive(0, 0, 8'h00, 2'd0, 1, 0);
        tick();
        drive(1, 0, 8'h30, 2'd0, 0, 0);
        tick();
        drive(0, 0, 8'h00, 2'd2, 0, 0);
        n_cmp++;
        if (occupancy !== 4'd1) begin
            n_err++; $display("FAIL overdeq_pre got=%0d exp=1", occupancy);
        end
        tick();
        drive(1, 0, 8'h40, 2'd0, 0, 0);
        n_cmp++;
        if ({occupancy, out_valid1} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL overdeq_empty got=%0d/%b exp=0/0", occupancy, out_valid1);
        end
        tick();
        drive(0, 0, 8'h00, 2'd3, 0, 0);
        n_cmp++;
        if ({occupancy, out_valid1, out_pc1} !== {4'd1, 1'b1, 8'h40}) begin
            n_err++; $display("FAIL overdeq_next got=%0d/%b/%h exp=1/1/40", occupancy, out_valid1, out_pc1);
        end
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if (occupancy !== 4'd0) begin
            n_err++; $display("FAIL deq3_clip got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 8'h50, 2'd0, 0, 0); tick();
        drive(1, 1, 8'h58, 2'd0, 0, 0); tick();
        drive(1, 0, 8'h60, 2'd0, 0, 0); tick();
        drive(1, 1, 8'h70, 2'd2, 1, 0);
        n_cmp++;
        if (occupancy !== 4'd5) begin
            n_err++; $display("FAIL flush_pre got=%0d exp=5", occupancy);
        end
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if ({occupancy, out_valid1, in_ready} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL flush_post got=%0d/%b/%b exp=0/0/1", occupancy, out_valid1, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 8'(8'h80 + 8 * k), 2'd0, 0, 0);
            tick();
        end
        drive(1, 1, 8'hA0, 2'd1, 0, 1);
        n_cmp++;
        if (occupancy !== 4'd6) begin
            n_err++; $display("FAIL rst_pre got=%0d exp=6", occupancy);
        end
        tick();
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if ({occupancy, out_valid1, in_ready} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL rst_post got=%0d/%b/%b exp=0/0/1", occupancy, out_valid1, in_ready);
        end
    endtask

    task automatic test_random();
        logic [1:0] dq;
        for (int c = 0; c < 600; c++) begin
            dq = (c < 300) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            drive(($urandom % 4) != 0, $urandom % 2 == 1, 8'($urandom), dq,
                  ($urandom % 40) == 0, ($urandom % 150) == 0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL random_%0d got=%h exp=%h", c, dut_vec(), model_vec());
            end
            tick();
        end
        drive(0, 0, 8'h00, 2'd0, 0, 0);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL random_end got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        drive(0, 0, 8'h00, 2'd0, 0, 1);
        test_reset();
        test_pair();
        test_fill();
        test_wrap();
        test_over_deq();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
